// File: rtl/an_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display: per-slot blanking guard,
// per-digit enable mask, global PWM brightness and frame-boundary commit of double-buffered data.
module an_scan_ctrl #(
  parameter int SLOT_CYCLES  = 250000,
  parameter int BLANK_CYCLES = 2500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_digit_data,
  input  logic [3:0]  i_en_in,
  input  logic [3:0]  i_bright_in,
  output logic        o_load_pending,
  output logic        o_frame_done,
  output logic [1:0]  o_sel,
  output logic [3:0]  o_an,
  output logic [3:0]  o_code
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  typedef logic [CW-1:0] slot_t;

  localparam slot_t SLOT_LAST = slot_t'(SLOT_CYCLES - 1);
  localparam slot_t BLANK_END = slot_t'(BLANK_CYCLES);

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_e;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  bright;
  } disp_t;

  localparam disp_t DISP_RST = '{data: 16'h0000, en: 4'hF, bright: 4'hF};

  slot_t      r_slot_cnt;
  logic [1:0] r_sel;
  logic [3:0] r_pwm_cnt;
  logic       r_pending;
  logic       r_wrap;
  disp_t      r_stage;
  disp_t      r_active;

  logic       w_slot_last;
  logic       w_boundary;
  phase_e     w_phase;
  logic [3:0] w_an_next;
  logic [3:0] w_code_next;
  disp_t      w_load_val;

  assign w_slot_last = (r_slot_cnt == SLOT_LAST);
  assign w_boundary  = w_slot_last && (r_sel == 2'd3);
  assign w_phase     = (r_slot_cnt < BLANK_END) ? PH_BLANK : PH_ON;
  assign w_load_val  = '{data: i_digit_data, en: i_en_in, bright: i_bright_in};

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_cnt <= '0;
      r_sel      <= 2'd0;
      r_pwm_cnt  <= 4'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_sel      <= r_sel + 2'd1;
      end else begin
        r_slot_cnt <= r_slot_cnt + slot_t'(1);
      end
    end
  end

  // Commit reads the old staging value, so a load on the boundary cycle waits a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage   <= DISP_RST;
      r_active  <= DISP_RST;
      r_pending <= 1'b0;
    end else begin
      if (w_boundary && r_pending) begin
        r_active <= r_stage;
      end
      if (i_load) begin
        r_stage   <= w_load_val;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_an_next   = 4'hF;
    w_code_next = r_active.data[{r_sel, 2'b00} +: 4];
    if (w_phase == PH_ON && r_active.en[r_sel] && (r_pwm_cnt <= r_active.bright)) begin
      w_an_next[r_sel] = 1'b0;
    end
  end

  // Output stage: everything visible in cycle n+1 comes from the counters of cycle n;
  // frame_done is delayed one more cycle so it lines up with o_sel showing digit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_an         <= 4'hF;
      o_code       <= 4'h0;
      o_sel        <= 2'd0;
      r_wrap       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_an         <= w_an_next;
      o_code       <= w_code_next;
      o_sel        <= r_sel;
      r_wrap       <= w_boundary;
      o_frame_done <= r_wrap;
    end
  end

  assign o_load_pending = r_pending;

endmodule

// File: tb/tb_an_scan_ctrl.sv
// Self-checking bench for an_scan_ctrl: a frame-arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_an_scan_ctrl;

  localparam int S     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * S;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] dd    = 16'h0000;
  logic [3:0]  en_in = 4'hF;
  logic [3:0]  br    = 4'hF;

  logic        o_load_pending;
  logic        o_frame_done;
  logic [1:0]  o_sel;
  logic [3:0]  o_an;
  logic [3:0]  o_code;

  int n_checks = 0;
  int n_fail   = 0;

  an_scan_ctrl #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load         (load),
    .i_digit_data   (dd),
    .i_en_in        (en_in),
    .i_bright_in    (br),
    .o_load_pending (o_load_pending),
    .o_frame_done   (o_frame_done),
    .o_sel          (o_sel),
    .o_an           (o_an),
    .o_code         (o_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the schedule is derived purely from the number of
  // clock edges since reset release (m_n), not from any counter registers.
  int          m_n;
  logic [15:0] m_sdata, m_adata;
  logic [3:0]  m_sen, m_aen, m_sbr, m_abr;
  bit          m_pend, m_prev_last;
  logic [1:0]  e_sel;
  logic [3:0]  e_an, e_code;
  bit          e_fd;

  task automatic model_reset();
    m_n         = 0;
    m_sdata     = 16'h0000; m_adata = 16'h0000;
    m_sen       = 4'hF;     m_aen   = 4'hF;
    m_sbr       = 4'hF;     m_abr   = 4'hF;
    m_pend      = 1'b0;
    m_prev_last = 1'b0;
    e_sel       = 2'd0;
    e_an        = 4'hF;
    e_code      = 4'h0;
    e_fd        = 1'b0;
  endtask

  task automatic model_step();
    int  slot, dig, pwm;
    bit  last;
    slot = m_n % S;
    dig  = (m_n / S) % 4;
    pwm  = m_n % 16;
    last = (m_n % FRAME) == FRAME - 1;
    e_sel  = 2'(dig);
    e_code = 4'((m_adata >> (4 * dig)) & 16'h000F);
    e_an   = 4'hF;
    if (slot >= B && m_aen[dig] && pwm <= int'(m_abr)) e_an[dig] = 1'b0;
    e_fd        = m_prev_last;
    m_prev_last = last;
    if (last) begin
      if (m_pend) begin
        m_adata = m_sdata; m_aen = m_sen; m_abr = m_sbr;
      end
      m_pend = 1'b0;
    end
    if (load) begin
      m_sdata = dd; m_sen = en_in; m_sbr = br;
      m_pend  = 1'b1;
    end
    m_n++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("m_sel",     32'(o_sel),          32'(e_sel));
      check("m_an",      32'(o_an),           32'(e_an));
      check("m_code",    32'(o_code),         32'(e_code));
      check("m_fdone",   32'(o_frame_done),   32'(e_fd));
      check("m_pending", 32'(o_load_pending), 32'(m_pend));
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] b);
    dd = d; en_in = e; br = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (o_frame_done) seen = 1'b1;
    end
    check("fd_seen", 32'(seen), 32'd1);
  endtask

  task automatic count_lows(output int total, output int odd_low);
    total = 0; odd_low = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      for (int d = 0; d < 4; d++) if (!o_an[d]) total++;
      if (!o_an[1] || !o_an[3]) odd_low++;
    end
  endtask

  initial begin
    int cnt, tot, odd;
    bit hit;

    repeat (3) @(negedge clk);
    check("rst_an",   32'(o_an),           32'hF);
    check("rst_pend", 32'(o_load_pending), 32'd0);
    rst_n = 1'b1;

    // 1: defaults after release
    @(negedge clk);
    check("t1_blank_an", 32'(o_an),   32'hF);
    check("t1_sel0",     32'(o_sel),  32'd0);
    repeat (2) @(negedge clk);
    check("t1_on_an",    32'(o_an),   32'hE);
    cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (o_frame_done) cnt++;
    end
    check("t1_fd_per_2frames", 32'(cnt), 32'd2);

    // 2: mid-frame load commits at the next frame
    do_load(16'hA321, 4'hF, 4'hF);
    check("t2_pending", 32'(o_load_pending), 32'd1);
    check("t2_old_code", 32'(o_code), 32'h0);
    wait_fd();
    check("t2_code0", 32'(o_code), 32'h1);
    check("t2_sel0",  32'(o_sel),  32'd0);
    check("t2_pend0", 32'(o_load_pending), 32'd0);
    repeat (S) @(negedge clk);
    check("t2_code1", 32'(o_code), 32'h2);
    repeat (S) @(negedge clk);
    check("t2_code2", 32'(o_code), 32'h3);
    repeat (S) @(negedge clk);
    check("t2_code3", 32'(o_code), 32'hA);
    check("t2_sel3",  32'(o_sel),  32'd3);

    // 3: two loads in one frame, last write wins
    do_load(16'h1111, 4'hF, 4'hF);
    @(negedge clk);
    do_load(16'h2222, 4'hF, 4'hF);
    wait_fd();
    check("t3_code", 32'(o_code), 32'h2);

    // 4: load exactly on the boundary cycle
    do_load(16'h4444, 4'hF, 4'hF);
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      if (m_n % FRAME == FRAME - 1) hit = 1'b1;
      else @(negedge clk);
    end
    check("t4_boundary_found", 32'(hit), 32'd1);
    do_load(16'h5555, 4'hF, 4'hF);
    check("t4_pend_kept", 32'(o_load_pending), 32'd1);
    wait_fd();
    check("t4_first_commit", 32'(o_code), 32'h4);
    check("t4_pend_still",   32'(o_load_pending), 32'd1);
    wait_fd();
    check("t4_second_commit", 32'(o_code), 32'h5);
    check("t4_pend_clear",    32'(o_load_pending), 32'd0);

    // 5: enable mask and brightness
    do_load(16'h5555, 4'b0101, 4'hF);
    wait_fd();
    count_lows(tot, odd);
    check("t5_mask_odd_low", 32'(odd), 32'd0);
    check("t5_mask_total",   32'(tot), 32'd12);
    do_load(16'h5555, 4'hF, 4'd3);
    wait_fd();
    count_lows(tot, odd);
    check("t5_bright3_total", 32'(tot), 32'd4);

    // 6: async reset mid-slot of digit 2 with pending data
    do_load(16'h9876, 4'hF, 4'hF);
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (o_sel == 2'd2) hit = 1'b1;
    end
    check("t6_sel2_found", 32'(hit), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_an",   32'(o_an),           32'hF);
    check("t6_rst_sel",  32'(o_sel),          32'd0);
    check("t6_rst_pend", 32'(o_load_pending), 32'd0);
    check("t6_rst_code", 32'(o_code),         32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_restart_an", 32'(o_an), 32'hE);
    wait_fd();
    check("t6_default_code", 32'(o_code), 32'h0);
    check("t6_pend_after",   32'(o_load_pending), 32'd0);
    repeat (S) @(negedge clk);
    check("t6_default_code1", 32'(o_code), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
